// File: rtl/aes_pkg.sv
// Shared AES-128 constants: widths, round count, S-box and Rcon tables.
package aes_pkg;

    localparam int BLOCK_W = 128;
    localparam int KEY_W   = 128;

    localparam logic [3:0] ROUNDS = 4'd10;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        unique case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box lookup.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    // Entry i sits at bit 8*(255-i), i.e. the inverted index.
    assign y = SBOX[{~a, 3'b000} +: 8];

endmodule

// File: rtl/top.sv
// Iterative AES-128 encryption of a fixed plaintext, one round per clock.
module top
    import aes_pkg::*;
#(
    parameter logic [BLOCK_W-1:0] PLAINTEXT =
        128'h00112233445566778899aabbccddeeff
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_W-1:0]   key,
    input  logic               __obs,
    output logic [BLOCK_W-1:0] out
);

    logic [BLOCK_W-1:0] state_q;
    logic [KEY_W-1:0]   rk_q;
    logic [3:0]         rnd_q;

    logic [BLOCK_W-1:0] sb;
    logic [BLOCK_W-1:0] sr;
    logic [BLOCK_W-1:0] mc;
    logic [KEY_W-1:0]   rk_next;
    logic [31:0]        rot;
    logic [31:0]        sw;
    logic [31:0]        t;
    logic [31:0]        w0;
    logic [31:0]        w1;
    logic [31:0]        w2;
    logic [31:0]        w3;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
        end
        return o;
    endfunction

    for (genvar i = 0; i < 16; i++) begin : g_sub
        aes_sbox u_sbox (
            .a (state_q[127-8*i -: 8]),
            .y (sb[127-8*i -: 8])
        );
    end

    assign rot = {rk_q[23:0], rk_q[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_ks
        aes_sbox u_sbox (
            .a (rot[31-8*i -: 8]),
            .y (sw[31-8*i -: 8])
        );
    end

    assign t       = sw ^ {rcon(rnd_q), 24'h000000};
    assign w0      = rk_q[127:96] ^ t;
    assign w1      = rk_q[95:64] ^ w0;
    assign w2      = rk_q[63:32] ^ w1;
    assign w3      = rk_q[31:0] ^ w2;
    assign rk_next = {w0, w1, w2, w3};

    assign sr = shift_rows(sb);
    assign mc = mix_columns(sr);

    // A start strobe always wins, so it also aborts a running block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
            rk_q    <= '0;
            rnd_q   <= '0;
            out     <= '0;
        end else if (__obs) begin
            state_q <= PLAINTEXT ^ key;
            rk_q    <= key;
            rnd_q   <= 4'd1;
        end else if (rnd_q != 4'd0) begin
            rk_q <= rk_next;
            if (rnd_q == ROUNDS) begin
                state_q <= sr ^ rk_next;
                out     <= sr ^ rk_next;
                rnd_q   <= 4'd0;
            end else begin
                state_q <= mc ^ rk_next;
                rnd_q   <= rnd_q + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_top.sv
// Directed-vector bench for the iterative AES-128 block.
module tb_top;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KA = 128'h00000000000000000000000000000000;
    localparam logic [127:0] CA = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] KB = 128'h80000000000000000000000000000000;
    localparam logic [127:0] CB = 128'h0edd33d3c621e546455bd8ba1418bec8;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key1, key2, key3;
    logic         obs1, obs2, obs3;
    logic [127:0] out1, out2, out3;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    top u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .key   (key1),
        .__obs (obs1),
        .out   (out1)
    );

    top #(.PLAINTEXT(P2)) u_dut2 (
        .clk   (clk),
        .rst   (rst),
        .key   (key2),
        .__obs (obs2),
        .out   (out2)
    );

    top #(.PLAINTEXT(128'h0)) u_dut3 (
        .clk   (clk),
        .rst   (rst),
        .key   (key3),
        .__obs (obs3),
        .out   (out3)
    );

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else
            passed++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load1(input logic [127:0] k);
        key1 = k;
        obs1 = 1'b1;
        tick(1);
        obs1 = 1'b0;
    endtask

    task automatic load3(input logic [127:0] k);
        key3 = k;
        obs3 = 1'b1;
        tick(1);
        obs3 = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        key1 = '0;
        key2 = '0;
        key3 = '0;
        obs1 = 1'b0;
        obs2 = 1'b0;
        obs3 = 1'b0;
        #3;
        check("rst_out1", out1, '0);
        check("rst_out2", out2, '0);
        check("rst_out3", out3, '0);
        tick(2);
        rst = 1'b0;

        load1(K1);
        for (int i = 1; i < 10; i++) begin
            tick(1);
            check("fips_wait", out1, '0);
        end
        tick(1);
        check("fips_c1", out1, C1);
        tick(5);
        check("idle_hold", out1, C1);

        key2 = K2;
        obs2 = 1'b1;
        tick(1);
        obs2 = 1'b0;
        tick(9);
        check("c2_wait", out2, '0);
        tick(1);
        check("fips_c2", out2, C2);

        pulse_reset();
        check("reset_clr", out1, '0);
        load1(K1);
        for (int i = 0; i < 10; i++) begin
            key1 = {$urandom, $urandom, $urandom, $urandom};
            tick(1);
        end
        check("key_change", out1, C1);

        pulse_reset();
        load1(K1);
        tick(4);
        obs1 = 1'b1;
        tick(1);
        obs1 = 1'b0;
        for (int i = 1; i < 10; i++) begin
            tick(1);
            check("abort_wait", out1, '0);
        end
        tick(1);
        check("abort_c1", out1, C1);

        load1(K2);
        tick(5);
        @(posedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst", out1, '0);
        tick(2);
        rst = 1'b0;
        tick(15);
        check("post_rst", out1, '0);

        load3(KA);
        tick(10);
        check("b2b_a", out3, CA);
        load3(KB);
        check("b2b_hold0", out3, CA);
        tick(9);
        check("b2b_hold9", out3, CA);
        tick(1);
        check("b2b_b", out3, CB);
        tick(3);
        check("b2b_hold", out3, CB);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter PLAINTEXT, default 128'h00112233445566778899aabbccddeeff, fixed 128-bit block encrypted under the supplied key.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 key  input  128  AES-128 cipher key, FIPS-197 byte order (byte 0 = bits [127:120]).
REQ-005 __obs  input  1  start strobe; when sampled high, loads key and begins one encryption.
REQ-006 out  output  128  most recent completed ciphertext, registered.

Function
REQ-007 The block SHALL implement iterative AES-128 encryption (FIPS-197) of PLAINTEXT under key, one round per clock.
REQ-008 Internal state: 128-bit state register, 128-bit round-key register, 4-bit round counter rnd (0 = idle, 1..10 = active).
REQ-009 Load edge (__obs=1): state <= PLAINTEXT ^ key; round key <= key; rnd <= 1; key captured here only.
REQ-010 Active edge with rnd=1..9: state <= MixColumns(ShiftRows(SubBytes(state))) ^ next round key; round key <= next round key; rnd <= rnd+1.
REQ-011 Active edge with rnd=10: final round without MixColumns; result written to out; rnd <= 0.
REQ-012 Next round key: standard expansion: RotWord, SubWord, XOR Rcon[rnd] (01,02,04,08,10,20,40,80,1b,36) into word 0, then chained XORs for words 1..3.
REQ-013 Latency: out holds ciphertext after the 10th rising edge following the load edge; unchanged until the next completion.
REQ-014 __obs=1 while active SHALL abort the current operation and restart from REQ-009 with the present key; out not updated by the aborted run.
REQ-015 key changes after the load edge SHALL NOT affect the running encryption.
REQ-016 __obs=0 while idle: no state change; out holds.
REQ-017 MixColumns arithmetic in GF(2^8) with polynomial 0x11b (xtime: shift left, XOR 0x1b on carry).

Reset
REQ-018 rst high SHALL immediately clear out, state, round-key register and rnd to 0 (idle).
REQ-019 Reset asserted mid-encryption SHALL discard the operation; no output produced after release until a new __obs.
REQ-020 First load accepted on the first rising edge with rst low and __obs high.

Structure
REQ-021 Shared package holds the Rcon table, round-count constant (10) and block/key width constants.
REQ-022 One sub-module aes_sbox (8-bit in, 8-bit out, combinational forward S-box); 20 instances (16 datapath, 4 key expansion).
REQ-023 ShiftRows, MixColumns and key expansion as combinational functions/logic in top; no other sub-modules.

Verification
REQ-024 PLAINTEXT default, key 000102030405060708090a0b0c0d0e0f, __obs pulse one cycle -> out = 69c4e0d86a7b0430d8cdb78070b4c55a exactly 10 edges after load.
REQ-025 PLAINTEXT=3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c -> out = 3925841d02dc09fbdc118597196a0b32.
REQ-026 Load with key from REQ-024, change key every cycle thereafter -> out still 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-027 Load, re-pulse __obs at edge 5 with same key -> out stays 0 until 10 edges after the second load, then REQ-024 value.
REQ-028 Assert rst at edge 6 of an encryption -> out = 0 immediately and remains 0 with __obs low.
REQ-029 Back-to-back: two loads 11 cycles apart with different keys -> out shows each ciphertext in turn, holding between.
